fft_input_framer: RTL and testbench

- Upstream feeder for the radix-2 FFT core. It decimates a packed complex sample stream by RATE and collects N-sample frames in a ping-pong buffer, writing each sample to its bit-reversed address.
- It then streams each frame to the FFT stage with valid/ready handshake and start/end-of-frame markers.
- The FFT core therefore receives bit-reversed-order input suited to in-place decimation-in-time butterflies.

---
 rtl/fft_input_framer.sv | 88 ++++++++
 tb/tb_fft_input_framer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fft_input_framer.sv
// fft_input_framer: decimates a packed complex stream by RATE, frames N samples into
// bit-reversed ping-pong banks and streams each frame out with valid/ready and sop/eop.
module fft_input_framer #(
    parameter int N          = 16,
    parameter int DATA_WIDTH = 8,
    parameter int RATE       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [2*DATA_WIDTH-1:0] in_data,
    output logic [2*DATA_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sop,
    output logic                    out_eop,
    output logic                    overflow
);
    localparam int LOG2N = $clog2(N);
    localparam int CW    = RATE > 1 ? $clog2(RATE) : 1;

    typedef enum logic {FILL, DROP} wr_state_t;
    typedef enum logic {IDLE, STREAM} rd_state_t;

    wr_state_t wr_state, wr_state_nx;
    rd_state_t rd_state, rd_state_nx;
    logic [CW-1:0] cnt;
    logic [LOG2N-1:0] wr_idx, wr_addr, rd_idx;
    logic wr_bank, rd_bank;
    logic [1:0] full;
    logic strobe, drop, wr_en, wr_last, xfer, rd_last;
    logic [2*DATA_WIDTH-1:0] mem [2*N];

    assign strobe = enable && cnt == CW'(RATE - 1);

    for (genvar i = 0; i < LOG2N; i++) begin : g_rev
        assign wr_addr[i] = wr_idx[LOG2N-1-i];
    end

    // DROP only discards while the target bank is still full, so a bank freed by the reader is usable next cycle
    always_comb begin
        drop        = wr_state == DROP && full[wr_bank];
        wr_en       = strobe && !drop;
        wr_last     = wr_en && wr_idx == LOG2N'(N - 1);
        wr_state_nx = (wr_last && full[!wr_bank]) || drop ? DROP : FILL;
        xfer        = rd_state == STREAM && out_ready;
        rd_last     = xfer && rd_idx == LOG2N'(N - 1);
        rd_state_nx = rd_state == IDLE ? (full[rd_bank] ? STREAM : IDLE) : (rd_last ? IDLE : STREAM);
        out_valid   = rd_state == STREAM;
        out_data    = out_valid ? mem[{rd_bank, rd_idx}] : '0;
        out_sop     = out_valid && rd_idx == '0;
        out_eop     = out_valid && rd_idx == LOG2N'(N - 1);
        overflow    = strobe && drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            wr_idx   <= '0;
            rd_idx   <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            full     <= '0;
            wr_state <= FILL;
            rd_state <= IDLE;
        end else begin
            cnt      <= (!enable || strobe) ? '0 : cnt + 1'b1;
            wr_idx   <= !enable ? '0 : wr_idx + LOG2N'(wr_en);
            wr_state <= wr_state_nx;
            rd_state <= rd_state_nx;
            if (xfer)
                rd_idx <= rd_idx + 1'b1;
            if (wr_last)
                wr_bank <= !wr_bank;
            if (rd_last) begin
                rd_bank       <= !rd_bank;
                full[rd_bank] <= 1'b0;
            end
            if (wr_last)
                full[wr_bank] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wr_bank, wr_addr}] <= in_data;
    end
endmodule

// File: tb/tb_fft_input_framer.sv
// tb_fft_input_framer: directed scenarios; expected words go into a queue that a negedge monitor
// pops as the framer hands words out.
module tb_fft_input_framer;
    localparam int N = 16, DW = 8, RATE = 4;

    typedef struct packed {
        logic [2*DW-1:0] d;
        logic            s;
        logic            e;
    } exp_t;

    logic clk = 0, rst = 1, enable = 0, out_ready = 0;
    logic [2*DW-1:0] in_data = '0;
    logic [2*DW-1:0] out_data;
    logic out_valid, out_sop, out_eop, overflow;

    int pass_cnt = 0, total = 0, ovf_cnt = 0, sop_cnt = 0, eop_cnt = 0, ph = 0, base = 0, lows = 0;
    logic [7:0] imx = '0;
    logic prev_eop = 0;
    exp_t q[$];
    int br[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    fft_input_framer #(.N(N), .DATA_WIDTH(DW), .RATE(RATE)) dut (
        .clk(clk), .rst(rst), .enable(enable), .in_data(in_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [2*DW-1:0] gen(input int k);
        logic [7:0] v;
        v = 8'(k + 1);
        return {v, v ^ imx};
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic push_frame(input int b);
        for (int p = 0; p < N; p++) q.push_back({gen(b + br[p]), 1'(p == 0), 1'(p == N - 1)});
    endtask

    // one clock of stimulus; ph counts enabled cycles so sample k sits on in_data for its RATE cycles
    task automatic tick();
        in_data = enable ? gen(base + ph / RATE) : '0;
        @(negedge clk);
        ph = enable ? ph + 1 : 0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic drain(input int limit);
        int c = 0;
        while (q.size() != 0 && c < limit) begin
            tick();
            c++;
        end
        chk(q.size() == 0, "drain", q.size(), 0);
        ticks(8);
    endtask

    task automatic do_reset();
        enable = 0;
        out_ready = 0;
        rst = 1;
        ticks(2);
        rst = 0;
        q.delete();
        ph = 0;
        base = 0;
        ovf_cnt = 0;
        sop_cnt = 0;
        eop_cnt = 0;
    endtask

    always @(negedge clk) begin
        #2;
        if (overflow) ovf_cnt++;
        if (prev_eop) chk(!out_valid, "bubble", out_valid, 0);
        prev_eop = 0;
        if (out_valid) begin
            if (q.size() == 0) chk(0, "unexpected word", {out_data, out_sop, out_eop}, 0);
            else begin
                chk({out_data, out_sop, out_eop} == q[0], "word", {out_data, out_sop, out_eop}, q[0]);
                if (out_ready) begin
                    prev_eop = out_eop;
                    sop_cnt += out_sop;
                    eop_cnt += out_eop;
                    void'(q.pop_front());
                end
            end
        end else chk(out_data == '0 && !out_sop && !out_eop, "idle outputs", {out_data, out_sop, out_eop}, 0);
    end

    initial begin
        @(negedge clk);
        #1 chk(!out_valid && out_data == '0 && !overflow, "reset outputs", {out_valid, out_data, overflow}, 0);
        tick();
        do_reset();

        // single frame, re=im
        imx = 8'h00;
        push_frame(0);
        out_ready = 1;
        enable = 1;
        ticks(64);
        enable = 0;
        #1 chk(!out_valid, "valid before capture+1", out_valid, 0);
        tick();
        #1 chk(out_valid, "valid at capture+1", out_valid, 1);
        drain(100);
        chk(sop_cnt == 1 && eop_cnt == 1, "single sop/eop", {sop_cnt[15:0], eop_cnt[15:0]}, 32'h0001_0001);

        // backpressure: two frames held, then overflow every strobe until bank 0 is freed
        do_reset();
        imx = 8'h5A;
        push_frame(0);
        push_frame(16);
        enable = 1;
        ticks(200);
        #1 chk(ovf_cnt == 18, "overflow during stall", ovf_cnt, 18);
        out_ready = 1;
        ticks(40);
        #1 chk(ovf_cnt == 22, "overflow until free", ovf_cnt, 22);
        enable = 0;
        drain(100);
        chk(ovf_cnt == 22, "no overflow after readout", ovf_cnt, 22);

        // async reset while stalled and dropping
        do_reset();
        enable = 1;
        push_frame(0);
        ticks(143);
        #1 chk(overflow && out_valid, "pre-reset drop", {overflow, out_valid}, 3);
        rst = 1;
        #1 chk(!out_valid && out_data == '0 && !overflow, "async reset", {out_valid, out_data, overflow}, 0);
        q.delete();
        tick();
        do_reset();
        ticks(10);

        // enable abort after 5 captures
        imx = 8'hA5;
        out_ready = 1;
        enable = 1;
        ticks(20);
        enable = 0;
        ticks(7);
        base = 100;
        push_frame(100);
        enable = 1;
        ticks(64);
        enable = 0;
        drain(100);
        chk(sop_cnt == 1 && eop_cnt == 1, "abort sop/eop", {sop_cnt[15:0], eop_cnt[15:0]}, 32'h0001_0001);

        // continuous streaming, 10 frames
        do_reset();
        imx = 8'h33;
        for (int f = 0; f < 10; f++) push_frame(16 * f);
        out_ready = 1;
        enable = 1;
        ticks(640);
        enable = 0;
        drain(200);
        chk(ovf_cnt == 0, "stream overflow", ovf_cnt, 0);
        chk(sop_cnt == 10, "stream sop count", sop_cnt, 10);
        chk(eop_cnt == 10, "stream eop count", eop_cnt, 10);

        // random out_ready, never low more than twice in a row: drain stays under fill time
        do_reset();
        imx = 8'hC3;
        for (int f = 0; f < 6; f++) push_frame(16 * f);
        enable = 1;
        for (int c = 0; c < 384; c++) begin
            out_ready = ($urandom_range(0, 1) == 1) || lows >= 2;
            lows = out_ready ? 0 : lows + 1;
            tick();
        end
        enable = 0;
        out_ready = 1;
        drain(200);
        chk(ovf_cnt == 0, "random overflow", ovf_cnt, 0);
        chk(sop_cnt == 6 && eop_cnt == 6, "random sop/eop", {sop_cnt[15:0], eop_cnt[15:0]}, 32'h0006_0006);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
